// File: rtl/ham_dec_arbiter_if.sv
// Requester, shared-decoder and result signals of ham_dec_arbiter.
// The arbiter is the slave side of this bus; the environment (requesters, decoder, consumer) is the master.
interface ham_dec_arbiter_if;
    logic       vld0;
    logic [6:0] cw0;
    logic       rdy0;
    logic       vld1;
    logic [6:0] cw1;
    logic       rdy1;
    logic [6:0] dec_codeword;
    logic [3:0] dec_data;
    logic [2:0] dec_pos;
    logic       dec_err;
    logic       out_valid;
    logic       out_ready;
    logic       out_id;
    logic [3:0] out_data;
    logic [2:0] out_pos;
    logic       out_err;

    modport slave (
        input  vld0, cw0, vld1, cw1, dec_data, dec_pos, dec_err, out_ready,
        output rdy0, rdy1, dec_codeword, out_valid, out_id, out_data, out_pos, out_err
    );

    modport master (
        output vld0, cw0, vld1, cw1, dec_data, dec_pos, dec_err, out_ready,
        input  rdy0, rdy1, dec_codeword, out_valid, out_id, out_data, out_pos, out_err
    );
endinterface

// File: rtl/ham_dec_arbiter.sv
// Round-robin arbiter feeding one external Hamming(7,4) decoder from two requesters,
// returning tagged results over valid/ready and keeping saturating per-requester error counts.
//
// state | meaning
// IDLE  | arbitrate, accept one codeword
// DEC   | codeword registered on dec_codeword, capture decoder result
// OUT   | result presented, wait for out_ready
module ham_dec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ham_dec_arbiter_if.slave bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       id_reg;
    logic       grant;
    logic       rdy0;
    logic       rdy1;
    logic       hs;
    logic [6:0] codeword;
    logic       out_valid;
    logic       out_id;
    logic [3:0] out_data;
    logic [2:0] out_pos;
    logic       out_err;
    logic       inc0;
    logic       inc1;

    // Requester 1 wins only when alone or when requester 0 was served last.
    always_comb begin
        grant = 1'b0;
        if (bus.vld1 && (!bus.vld0 || !last))
            grant = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = DEC;
            DEC:     state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state == IDLE) begin
            rdy0 = bus.vld0 && !grant;
            rdy1 = bus.vld1 && grant;
        end
        hs = rdy0 || rdy1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codeword  <= 7'd0;
            id_reg    <= 1'b0;
            last      <= 1'b1;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_data  <= 4'd0;
            out_pos   <= 3'd0;
            out_err   <= 1'b0;
        end else begin
            if (hs) begin
                codeword <= grant ? bus.cw1 : bus.cw0;
                id_reg   <= grant;
                last     <= grant;
            end
            if (state == DEC) begin
                out_data  <= bus.dec_data;
                out_pos   <= bus.dec_pos;
                out_err   <= bus.dec_err;
                out_id    <= id_reg;
                out_valid <= 1'b1;
            end else if (state == OUT && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign inc0 = (state == DEC) && bus.dec_err && !id_reg;
    assign inc1 = (state == DEC) && bus.dec_err && id_reg;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (clr_cnt) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else begin
            if (inc0 && err_cnt0 != CNT_MAX)
                err_cnt0 <= err_cnt0 + 1'b1;
            if (inc1 && err_cnt1 != CNT_MAX)
                err_cnt1 <= err_cnt1 + 1'b1;
        end
    end

    assign bus.rdy0         = rdy0;
    assign bus.rdy1         = rdy1;
    assign bus.dec_codeword = codeword;
    assign bus.out_valid    = out_valid;
    assign bus.out_id       = out_id;
    assign bus.out_data     = out_data;
    assign bus.out_pos      = out_pos;
    assign bus.out_err      = out_err;
endmodule

// File: tb/tb_ham_dec_arbiter.sv
// Directed bench for ham_dec_arbiter with a behavioural Hamming(7,4) decoder on the dec_* side.
// Codeword bit i is Hamming position i+1; data = {pos7, pos6, pos5, pos3}.
module tb_ham_dec_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [1:0] err_cnt0;
    logic [1:0] err_cnt1;
    int         n_vec = 0;
    int         n_miss = 0;

    ham_dec_arbiter_if bus ();

    ham_dec_arbiter #(.CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr_cnt  (clr_cnt),
        .err_cnt0 (err_cnt0),
        .err_cnt1 (err_cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ham_model(input logic [6:0] cw);
        logic [6:0] c;
        logic [2:0] s;
        c = cw;
        s = 3'd0;
        for (int i = 0; i < 7; i++)
            if (c[i]) s = s ^ 3'(i + 1);
        if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
        return {s != 3'd0, s, c[6], c[5], c[4], c[2]};
    endfunction

    always_comb {bus.dec_err, bus.dec_pos, bus.dec_data} = ham_model(bus.dec_codeword);

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise a request, wait (bounded) for its rdy, release right after the accepting edge.
    task automatic req(input bit r, input logic [6:0] cw);
        int n;
        bit got;
        @(posedge clk); #1;
        if (r) begin bus.vld1 = 1'b1; bus.cw1 = cw; end
        else   begin bus.vld0 = 1'b1; bus.cw0 = cw; end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if ((r ? bus.rdy1 : bus.rdy0) === 1'b1) got = 1'b1;
            n++;
        end
        if (!got) check_vec("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (r) bus.vld1 = 1'b0;
        else   bus.vld0 = 1'b0;
    endtask

    task automatic run(input bit r, input logic [6:0] cw, input logic [3:0] ed, input logic [2:0] ep,
                       input logic ee, input logic [1:0] c0, input logic [1:0] c1, input bit clr_dec);
        req(r, cw);
        if (clr_dec) clr_cnt = 1'b1;
        @(negedge clk);
        check_vec("dec_valid", 32'(bus.out_valid), 32'd0);
        check_vec("dec_rdy", 32'({bus.rdy0, bus.rdy1}), 32'd0);
        check_vec("dec_codeword", 32'(bus.dec_codeword), 32'(cw));
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        check_vec("out_valid", 32'(bus.out_valid), 32'd1);
        check_vec("out_id", 32'(bus.out_id), 32'(r));
        check_vec("out_data", 32'(bus.out_data), 32'(ed));
        check_vec("out_pos", 32'(bus.out_pos), 32'(ep));
        check_vec("out_err", 32'(bus.out_err), 32'(ee));
        check_vec("err_cnt0", 32'(err_cnt0), 32'(c0));
        check_vec("err_cnt1", 32'(err_cnt1), 32'(c1));
        @(negedge clk);
        check_vec("consumed", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int   order[$];
        bit   both_seen;
        int   n;

        bus.vld0 = 1'b0; bus.cw0 = 7'd0;
        bus.vld1 = 1'b0; bus.cw1 = 7'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_vec("rst_outs", 32'({bus.out_valid, bus.out_id, bus.out_data, bus.out_pos, bus.out_err}), 32'd0);
        check_vec("rst_codeword", 32'(bus.dec_codeword), 32'd0);
        check_vec("rst_cnt", 32'({err_cnt0, err_cnt1}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single-bit error at position 7, then a clean zero word from requester 1
        run(1'b0, 7'b0010101, 4'b1011, 3'd7, 1'b1, 2'd1, 2'd0, 1'b0);
        run(1'b1, 7'b0000000, 4'b0000, 3'd0, 1'b0, 2'd1, 2'd0, 1'b0);
        run(1'b1, 7'b1111111, 4'b1111, 3'd0, 1'b0, 2'd1, 2'd0, 1'b0);

        // both requesters continuously valid: grants must alternate starting with 0
        @(posedge clk); #1;
        bus.vld0 = 1'b1; bus.cw0 = 7'b1010101;
        bus.vld1 = 1'b1; bus.cw1 = 7'b1111111;
        both_seen = 1'b0;
        n = 0;
        while (order.size() < 4 && n < 40) begin
            @(negedge clk);
            if (bus.rdy0 && bus.rdy1) both_seen = 1'b1;
            if (bus.rdy0) order.push_back(0);
            if (bus.rdy1) order.push_back(1);
            n++;
        end
        @(posedge clk); #1;
        bus.vld0 = 1'b0;
        bus.vld1 = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("alt_count", 32'(order.size()), 32'd4);
        check_vec("alt_both_rdy", 32'(both_seen), 32'd0);
        if (order.size() == 4)
            check_vec("alt_order", 32'({order[0][0], order[1][0], order[2][0], order[3][0]}), 32'b0101);
        check_vec("alt_cnt", 32'({err_cnt0, err_cnt1}), 32'({2'd1, 2'd0}));

        // consumer stall: result held, no new accept while requester 1 waits
        bus.out_ready = 1'b0;
        req(1'b0, 7'b1010111);
        @(negedge clk);
        @(posedge clk); #1;
        bus.vld1 = 1'b1; bus.cw1 = 7'b0000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_vec("stall_hold",
                      32'({bus.out_valid, bus.out_id, bus.out_data, bus.out_pos, bus.out_err, bus.rdy0, bus.rdy1}),
                      32'({1'b1, 1'b0, 4'b1011, 3'd2, 1'b1, 1'b0, 1'b0}));
        end
        check_vec("stall_cnt0", 32'(err_cnt0), 32'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.vld1 = 1'b0;
        @(negedge clk);
        check_vec("stall_last", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check_vec("stall_consumed", 32'(bus.out_valid), 32'd0);

        // counter clear, then saturation at 3
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        check_vec("clr_cnt", 32'({err_cnt0, err_cnt1}), 32'd0);
        run(1'b0, 7'b0010101, 4'b1011, 3'd7, 1'b1, 2'd1, 2'd0, 1'b0);
        run(1'b0, 7'b1010111, 4'b1011, 3'd2, 1'b1, 2'd2, 2'd0, 1'b0);
        run(1'b0, 7'b0000001, 4'b0000, 3'd1, 1'b1, 2'd3, 2'd0, 1'b0);
        run(1'b0, 7'b0010101, 4'b1011, 3'd7, 1'b1, 2'd3, 2'd0, 1'b0);
        run(1'b0, 7'b1010111, 4'b1011, 3'd2, 1'b1, 2'd3, 2'd0, 1'b0);
        // clear coincident with an increment
        run(1'b0, 7'b0000001, 4'b0000, 3'd1, 1'b1, 2'd0, 2'd0, 1'b1);

        // reset during DEC discards the transaction and restores the round-robin pointer
        req(1'b0, 7'b0010101);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("rstdec_outs", 32'({bus.out_valid, bus.out_id, bus.out_data, bus.out_pos, bus.out_err}), 32'd0);
        check_vec("rstdec_codeword", 32'(bus.dec_codeword), 32'd0);
        check_vec("rstdec_cnt", 32'({err_cnt0, err_cnt1}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.vld0 = 1'b1; bus.cw0 = 7'b1010101;
        bus.vld1 = 1'b1; bus.cw1 = 7'b1111111;
        @(negedge clk);
        check_vec("rstdec_grant", 32'({bus.rdy0, bus.rdy1}), 32'b10);
        @(posedge clk); #1;
        bus.vld0 = 1'b0;
        bus.vld1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_vec("rstdec_after_id", 32'({bus.out_valid, bus.out_id, bus.out_data}), 32'({1'b1, 1'b0, 4'b1011}));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
